// File: rtl/vec_issue_unit.sv
// Scalar-side issue front end for the vector co-processor: buffers vector instructions
// with their scalar operands, dispatches them in order and writes vl back for vset* ops.
module vec_issue_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sc_vec_valid,
    input  logic [XLEN-1:0] sc_vec_inst,
    input  logic [XLEN-1:0] sc_rs1_data,
    input  logic [XLEN-1:0] sc_rs2_data,
    output logic            sc_vec_ready,
    input  logic            sc_flush,
    output logic            sc_illegal,
    output logic            vec_inst_valid,
    output logic [XLEN-1:0] vec_inst,
    output logic [XLEN-1:0] vec_rs1_data,
    output logic [XLEN-1:0] vec_rs2_data,
    input  logic            vec_pro_ready,
    input  logic            vec_vl_resp_valid,
    input  logic [XLEN-1:0] vec_vl_resp,
    output logic            sc_rd_wr_en,
    output logic [4:0]      sc_rd_addr,
    output logic [XLEN-1:0] sc_rd_data,
    output logic            vec_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = '0;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [6:0] V_ARITH    = 7'b1010111;
    localparam logic [6:0] V_LOAD     = 7'b0000111;
    localparam logic [6:0] V_STORE    = 7'b0100111;
    localparam logic [2:0] CFG_FUNCT3 = 3'b111;

    localparam logic [0:0] ST_DISPATCH = 1'b0;
    localparam logic [0:0] ST_WAIT_VL  = 1'b1;

    function automatic logic is_vec_opcode(input logic [XLEN-1:0] inst);
        return (inst[6:0] == V_ARITH) || (inst[6:0] == V_LOAD) || (inst[6:0] == V_STORE);
    endfunction

    function automatic logic is_config(input logic [XLEN-1:0] inst);
        return (inst[6:0] == V_ARITH) && (inst[14:12] == CFG_FUNCT3);
    endfunction

    logic [XLEN-1:0]  inst_mem [DEPTH];
    logic [XLEN-1:0]  rs1_mem  [DEPTH];
    logic [XLEN-1:0]  rs2_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [0:0]       state;
    logic [4:0]       rd_pending;

    logic accept;
    logic do_push;
    logic do_pop;
    logic vl_done;

    assign sc_vec_ready   = reset & (count < CNT_FULL) & ~sc_flush;
    assign accept         = sc_vec_valid & sc_vec_ready;
    assign do_push        = accept & is_vec_opcode(sc_vec_inst);
    assign vec_inst_valid = (count != CNT_ZERO) & (state == ST_DISPATCH);
    assign do_pop         = vec_inst_valid & vec_pro_ready & ~sc_flush;
    assign vl_done        = (state == ST_WAIT_VL) & vec_vl_resp_valid & ~sc_flush;
    assign vec_busy       = (count != CNT_ZERO) | (state == ST_WAIT_VL);

    assign vec_inst     = inst_mem[rd_ptr];
    assign vec_rs1_data = rs1_mem[rd_ptr];
    assign vec_rs2_data = rs2_mem[rd_ptr];

    // Storage stage: payload is not reset, only the pointers/count qualify it
    always_ff @(posedge clk) begin
        if (do_push) begin
            inst_mem[wr_ptr] <= sc_vec_inst;
            rs1_mem[wr_ptr]  <= sc_rs1_data;
            rs2_mem[wr_ptr]  <= sc_rs2_data;
        end
    end

    // Queue control and issue FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= PTR_ZERO;
            rd_ptr     <= PTR_ZERO;
            count      <= CNT_ZERO;
            state      <= ST_DISPATCH;
            rd_pending <= 5'd0;
            sc_illegal <= 1'b0;
        end else if (sc_flush) begin
            wr_ptr     <= PTR_ZERO;
            rd_ptr     <= PTR_ZERO;
            count      <= CNT_ZERO;
            state      <= ST_DISPATCH;
            rd_pending <= 5'd0;
            sc_illegal <= 1'b0;
        end else begin
            sc_illegal <= accept & ~is_vec_opcode(sc_vec_inst);
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
            case (state)
                ST_DISPATCH: begin
                    if (do_pop && is_config(vec_inst)) begin
                        state      <= ST_WAIT_VL;
                        rd_pending <= vec_inst[11:7];
                    end
                end
                default: begin
                    if (vec_vl_resp_valid) begin
                        state <= ST_DISPATCH;
                    end
                end
            endcase
        end
    end

    // Write-back stage: x0 destinations complete the handshake without a write
    always_ff @(posedge clk) begin
        if (!reset) begin
            sc_rd_wr_en <= 1'b0;
            sc_rd_addr  <= 5'd0;
            sc_rd_data  <= '0;
        end else begin
            sc_rd_wr_en <= vl_done & (rd_pending != 5'd0);
            if (vl_done && (rd_pending != 5'd0)) begin
                sc_rd_addr <= rd_pending;
                sc_rd_data <= vec_vl_resp;
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_unit.sv
// Directed bench for vec_issue_unit: dispatch, full FIFO, vset* write-back,
// illegal opcodes, flush and mid-operation reset.
module tb_vec_issue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sc_vec_valid = 1'b0;
    logic [31:0] sc_vec_inst = '0;
    logic [31:0] sc_rs1_data = '0;
    logic [31:0] sc_rs2_data = '0;
    logic        sc_vec_ready;
    logic        sc_flush = 1'b0;
    logic        sc_illegal;
    logic        vec_inst_valid;
    logic [31:0] vec_inst;
    logic [31:0] vec_rs1_data;
    logic [31:0] vec_rs2_data;
    logic        vec_pro_ready = 1'b0;
    logic        vec_vl_resp_valid = 1'b0;
    logic [31:0] vec_vl_resp = '0;
    logic        sc_rd_wr_en;
    logic [4:0]  sc_rd_addr;
    logic [31:0] sc_rd_data;
    logic        vec_busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] VADD     = 32'h0220_80D7;
    localparam logic [31:0] VSET_X5  = 32'h0080_72D7;
    localparam logic [31:0] VSET_X0  = 32'h0080_7057;
    localparam logic [31:0] SC_ADD   = 32'h0000_0033;

    vec_issue_unit #(.XLEN(32), .DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .sc_vec_valid     (sc_vec_valid),
        .sc_vec_inst      (sc_vec_inst),
        .sc_rs1_data      (sc_rs1_data),
        .sc_rs2_data      (sc_rs2_data),
        .sc_vec_ready     (sc_vec_ready),
        .sc_flush         (sc_flush),
        .sc_illegal       (sc_illegal),
        .vec_inst_valid   (vec_inst_valid),
        .vec_inst         (vec_inst),
        .vec_rs1_data     (vec_rs1_data),
        .vec_rs2_data     (vec_rs2_data),
        .vec_pro_ready    (vec_pro_ready),
        .vec_vl_resp_valid(vec_vl_resp_valid),
        .vec_vl_resp      (vec_vl_resp),
        .sc_rd_wr_en      (sc_rd_wr_en),
        .sc_rd_addr       (sc_rd_addr),
        .sc_rd_data       (sc_rd_data),
        .vec_busy         (vec_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sc_vec_valid      = 1'b0;
        sc_vec_inst       = '0;
        sc_rs1_data       = '0;
        sc_rs2_data       = '0;
        sc_flush          = 1'b0;
        vec_vl_resp_valid = 1'b0;
        vec_vl_resp       = '0;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
        sc_vec_valid = 1'b1;
        sc_vec_inst  = inst;
        sc_rs1_data  = rs1;
        sc_rs2_data  = rs2;
    endtask

    initial begin
        logic [31:0] exp_inst;

        // Reset state
        idle();
        reset = 1'b0;
        step();
        step();
        check_eq("rst_ready", sc_vec_ready, 0);
        check_eq("rst_valid", vec_inst_valid, 0);
        check_eq("rst_busy", vec_busy, 0);
        check_eq("rst_wr_en", sc_rd_wr_en, 0);
        check_eq("rst_illegal", sc_illegal, 0);
        check_eq("rst_rd_addr", sc_rd_addr, 0);
        check_eq("rst_rd_data", sc_rd_data, 0);
        reset = 1'b1;
        step();

        // Single vadd: visible the cycle after the push, popped, queue drains
        vec_pro_ready = 1'b1;
        offer(VADD, 32'd5, 32'd9);
        #1;
        check_eq("t1_ready", sc_vec_ready, 1);
        check_eq("t1_no_bypass", vec_inst_valid, 0);
        step();
        idle();
        #1;
        check_eq("t1_valid", vec_inst_valid, 1);
        check_eq("t1_inst", vec_inst, VADD);
        check_eq("t1_rs1", vec_rs1_data, 5);
        check_eq("t1_rs2", vec_rs2_data, 9);
        check_eq("t1_busy", vec_busy, 1);
        step();
        check_eq("t1_drained", vec_inst_valid, 0);
        check_eq("t1_busy_low", vec_busy, 0);

        // Fill to DEPTH with the consumer stalled; 5th offer refused
        vec_pro_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(32'h0000_0007 | ((i + 1) << 20), 100 + i, 200 + i);
            #1;
            check_eq($sformatf("t2_ready_%0d", i), sc_vec_ready, (i < 4) ? 1 : 0);
            step();
        end
        idle();
        #1;
        check_eq("t2_hold_valid", vec_inst_valid, 1);
        check_eq("t2_hold_inst", vec_inst, 32'h0010_0007);
        step();
        check_eq("t2_hold_stable", vec_inst, 32'h0010_0007);
        vec_pro_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_inst = 32'h0000_0007 | ((k + 1) << 20);
            #1;
            check_eq($sformatf("t2_drain_valid_%0d", k), vec_inst_valid, 1);
            check_eq($sformatf("t2_drain_inst_%0d", k), vec_inst, exp_inst);
            check_eq($sformatf("t2_drain_rs1_%0d", k), vec_rs1_data, 100 + k);
            step();
        end
        check_eq("t2_empty_valid", vec_inst_valid, 0);
        check_eq("t2_empty_busy", vec_busy, 0);

        // vsetvli x5 then vadd: stall until vl returns, write back 16
        offer(VSET_X5, 32'd0, 32'd0);
        step();
        offer(VADD, 32'd7, 32'd0);
        #1;
        check_eq("t3_cfg_valid", vec_inst_valid, 1);
        check_eq("t3_cfg_inst", vec_inst, VSET_X5);
        step();
        idle();
        #1;
        check_eq("t3_wait_valid", vec_inst_valid, 0);
        check_eq("t3_wait_busy", vec_busy, 1);
        step();
        check_eq("t3_wait_valid2", vec_inst_valid, 0);
        check_eq("t3_wait_wr_en", sc_rd_wr_en, 0);
        vec_vl_resp_valid = 1'b1;
        vec_vl_resp       = 32'd16;
        #1;
        check_eq("t3_resp_cycle_valid", vec_inst_valid, 0);
        step();
        idle();
        #1;
        check_eq("t3_wr_en", sc_rd_wr_en, 1);
        check_eq("t3_rd_addr", sc_rd_addr, 5);
        check_eq("t3_rd_data", sc_rd_data, 16);
        check_eq("t3_next_valid", vec_inst_valid, 1);
        check_eq("t3_next_inst", vec_inst, VADD);
        check_eq("t3_next_rs1", vec_rs1_data, 7);
        step();
        check_eq("t3_wr_en_once", sc_rd_wr_en, 0);
        check_eq("t3_addr_hold", sc_rd_addr, 5);
        check_eq("t3_data_hold", sc_rd_data, 16);
        check_eq("t3_busy_low", vec_busy, 0);

        // vsetvli x0: response retires without a write; stray response ignored
        offer(VSET_X0, 32'd0, 32'd0);
        step();
        idle();
        #1;
        check_eq("t4_cfg_inst", vec_inst, VSET_X0);
        step();
        check_eq("t4_wait_busy", vec_busy, 1);
        vec_vl_resp_valid = 1'b1;
        vec_vl_resp       = 32'd8;
        step();
        idle();
        #1;
        check_eq("t4_x0_wr_en", sc_rd_wr_en, 0);
        check_eq("t4_x0_data_hold", sc_rd_data, 16);
        check_eq("t4_back_dispatch", vec_busy, 0);
        vec_vl_resp_valid = 1'b1;
        vec_vl_resp       = 32'd99;
        step();
        idle();
        #1;
        check_eq("t4_stray_wr_en", sc_rd_wr_en, 0);
        check_eq("t4_stray_data", sc_rd_data, 16);

        // Illegal scalar opcode: one-cycle pulse, nothing queued
        offer(SC_ADD, 32'd1, 32'd2);
        step();
        idle();
        #1;
        check_eq("t5_illegal", sc_illegal, 1);
        check_eq("t5_valid", vec_inst_valid, 0);
        check_eq("t5_busy", vec_busy, 0);
        step();
        check_eq("t5_illegal_pulse", sc_illegal, 0);

        // Flush with three queued entries, WAIT_VL pending, push and vl response
        offer(VSET_X5, 32'd0, 32'd0);
        step();
        offer(32'h0010_0007, 32'd1, 32'd0);
        step();
        offer(32'h0020_0007, 32'd2, 32'd0);
        step();
        offer(32'h0030_0007, 32'd3, 32'd0);
        step();
        idle();
        #1;
        check_eq("t6_pre_busy", vec_busy, 1);
        check_eq("t6_pre_wait", vec_inst_valid, 0);
        sc_flush = 1'b1;
        offer(32'h00AA_0007, 32'd77, 32'd0);
        vec_vl_resp_valid = 1'b1;
        vec_vl_resp       = 32'd33;
        #1;
        check_eq("t6_flush_ready", sc_vec_ready, 0);
        step();
        idle();
        #1;
        check_eq("t6_busy", vec_busy, 0);
        check_eq("t6_valid", vec_inst_valid, 0);
        check_eq("t6_wr_en", sc_rd_wr_en, 0);
        check_eq("t6_rd_data", sc_rd_data, 16);
        offer(32'h0050_0007, 32'd55, 32'd0);
        step();
        idle();
        #1;
        check_eq("t6_after_valid", vec_inst_valid, 1);
        check_eq("t6_after_inst", vec_inst, 32'h0050_0007);
        check_eq("t6_after_rs1", vec_rs1_data, 55);
        step();
        check_eq("t6_after_empty", vec_busy, 0);

        // Reset mid-operation drops in-flight entries
        vec_pro_ready = 1'b0;
        offer(VADD, 32'd1, 32'd1);
        step();
        idle();
        #1;
        check_eq("t7_pre_busy", vec_busy, 1);
        reset = 1'b0;
        step();
        check_eq("t7_rst_busy", vec_busy, 0);
        check_eq("t7_rst_ready", sc_vec_ready, 0);
        reset = 1'b1;
        step();
        check_eq("t7_post_valid", vec_inst_valid, 0);
        check_eq("t7_post_addr", sc_rd_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_issue_unit.md
Name: vec_issue_unit

Overview:
- Scalar-side issue front end for the vector co-processor.
- Accepts vector instructions and their scalar operands (rs1/rs2 data) from the scalar core and buffers them in a small FIFO.
- Dispatches them in order to the vector processor using a valid/ready handshake against vec_pro_ready.
- For configuration instructions (vsetvli/vsetivli/vsetvl), stalls dispatch until the vector side returns the new vl, then writes that vl back to scalar rd.

Parameters:
- XLEN, 32, instruction and scalar data width.
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-low reset
- sc_vec_valid  input  1  scalar core offers an instruction
- sc_vec_inst  input  XLEN  instruction word
- sc_rs1_data  input  XLEN  scalar rs1 operand
- sc_rs2_data  input  XLEN  scalar rs2 operand
- sc_vec_ready  output  1  FIFO can accept
- sc_flush  input  1  discard all queued and pending work
- sc_illegal  output  1  one-cycle pulse: offered opcode is not a vector opcode
- vec_inst_valid  output  1  head entry presented to vector processor
- vec_inst  output  XLEN  head instruction
- vec_rs1_data  output  XLEN  head rs1 operand
- vec_rs2_data  output  XLEN  head rs2 operand
- vec_pro_ready  input  1  vector processor accepts the head entry
- vec_vl_resp_valid  input  1  vector side returns new vl
- vec_vl_resp  input  XLEN  new vl value
- sc_rd_wr_en  output  1  scalar register-file write strobe
- sc_rd_addr  output  5  scalar destination register
- sc_rd_data  output  XLEN  write data (vl)
- vec_busy  output  1  FIFO non-empty or waiting for vl

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset=0 resets on the rising clk edge).
- Reset values:
  - count=0; read and write pointers=0; state=DISPATCH.
  - sc_rd_wr_en=0, sc_rd_addr=0, sc_rd_data=0, sc_illegal=0.
  - vec_inst_valid=0, vec_busy=0.
  - sc_vec_ready=0 while reset=0.
- Legal opcodes (inst[6:0]): V_ARITH=7'b1010111, V_LOAD=7'b0000111, V_STORE=7'b0100111.
- Config instruction: opcode V_ARITH with inst[14:12]=3'b111.
- Push:
  - sc_vec_ready = reset & (count<DEPTH) & ~sc_flush.
  - On sc_vec_valid & sc_vec_ready with a legal opcode, write {inst, rs1, rs2} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - Illegal opcode: nothing is written; sc_illegal=1 in the next cycle for one cycle.
- Dispatch:
  - vec_inst_valid = (count>0) & (state==DISPATCH).
  - vec_inst / vec_rs1_data / vec_rs2_data are driven from FIFO storage at rd_ptr (registered storage, combinational read).
  - Pop on vec_inst_valid & vec_pro_ready; rd_ptr wraps modulo DEPTH.
  - Head data is held stable while vec_inst_valid=1 and vec_pro_ready=0.
- Latency: an entry pushed in cycle N can appear on vec_inst_valid no earlier than cycle N+1. There is no bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full is impossible because ready=0.
- FSM DISPATCH → WAIT_VL:
  - Transition occurs when the popped entry is a config instruction.
  - Capture rd_pending = inst[11:7] on the pop.
  - Dispatch is blocked in WAIT_VL; pushes continue.
- FSM WAIT_VL → DISPATCH:
  - Transition occurs on vec_vl_resp_valid.
  - In the next cycle: sc_rd_wr_en=1 for exactly one cycle, sc_rd_addr=rd_pending, sc_rd_data=vec_vl_resp.
  - If rd_pending==0, sc_rd_wr_en stays 0; the FSM still returns to DISPATCH.
  - The earliest next dispatch is the cycle after the response.
- vec_vl_resp_valid while in DISPATCH: ignored, no write.
- sc_rd_addr and sc_rd_data hold their last values when no write occurs.
- sc_flush (highest priority after reset):
  - Next cycle: count=0, pointers=0, state=DISPATCH, pending rd discarded.
  - A push offered in the same cycle is dropped (ready=0).
  - A pop in the same cycle has no effect on the FIFO.
  - A response arriving in the flush cycle produces no write.
- Reset mid-operation: identical to the reset values above; in-flight entries are lost.
- vec_busy = (count>0) | (state==WAIT_VL).

Test Plan:
- Reset, then push vadd (32'h0220_80D7) with rs1=5 and vec_pro_ready=1 → vec_inst_valid=1 next cycle with vec_inst=32'h022080D7, vec_rs1_data=5; popped; count returns to 0; vec_busy falls.
- Push 5 instructions back-to-back with vec_pro_ready=0, DEPTH=4 → sc_vec_ready=0 after the 4th push, 5th not accepted; raise ready → 4 entries drain in push order on 4 consecutive cycles, pointers wrap.
- Push vsetvli x5 (rd=5), then vadd; ready=1 → vsetvli dispatched, vec_inst_valid=0 while waiting; vec_vl_resp=16 → next cycle sc_rd_wr_en=1, sc_rd_addr=5, sc_rd_data=16; vadd dispatched the cycle after.
- vsetvli with rd=x0, response vl=8 → no sc_rd_wr_en; FSM returns to DISPATCH.
- Offer opcode 7'b0110011 (scalar ADD) → sc_illegal pulses one cycle, count unchanged, nothing dispatched.
- Three entries queued plus WAIT_VL pending; assert sc_flush with a concurrent push and a vl response → next cycle count=0, vec_busy=0, no rd write, flushed push absent.
